prog_loader: RTL
================

Name: prog_loader

Overview:
- Sits between the 8-bit CPU core and the shared 256-byte program/data RAM.
- After reset it holds the CPU off and fills RAM from a byte stream (UART receiver side, valid/ready).
- It then releases the CPU and passes the CPU memory bus straight through to RAM.
- Top level ties the CPU's reset to !cpu_run.

Parameters:
- ADDR_W, 8, RAM address width; loaded image starts at address 0.
- DATA_W, 8, byte width on the stream, RAM and CPU buses.

Ports:
- clk  in  1  system clock; all state updates on rising edge.
- rst  in  1  synchronous, active-high reset.
- rx_data  in  DATA_W  incoming load byte.
- rx_valid  in  1  rx_data valid.
- rx_ready  out  1  loader can accept a byte this cycle.
- reload  in  1  single-cycle pulse; restarts loading from RUN.
- cpu_addr  in  ADDR_W  CPU address.
- cpu_data_out  in  DATA_W  CPU write data.
- cpu_we  in  1  CPU write enable.
- cpu_data_in  out  DATA_W  read data returned to CPU.
- mem_addr  out  ADDR_W  RAM address.
- mem_wdata  out  DATA_W  RAM write data.
- mem_we  out  1  RAM write enable (RAM writes on rising edge).
- mem_rdata  in  DATA_W  RAM read data (asynchronous read).
- cpu_run  out  1  high = CPU released, bus in pass-through.
- load_err  out  1  checksum failure (optional feature only).

Behaviour:
- States: WAIT_LEN, LOAD, WRITE, CHECK, RUN, ERROR.
- Reset (any state, including mid-load): state=WAIT_LEN, ptr=0, count=0, byte register=0, sum=0, cpu_run=0, load_err=0, mem_we=0, rx_ready=1, cpu_data_in=0.
- A transfer is accepted on a cycle with rx_valid && rx_ready.
- WAIT_LEN:
  - rx_ready=1.
  - Accepted byte is the length N; N=0 means 256.
  - Store count=N, ptr=0, sum=0, then go to LOAD.
- LOAD:
  - rx_ready=1.
  - Accepted byte is latched into the byte register; go to WRITE.
  - Idle cycles (rx_valid=0) are allowed indefinitely.
- WRITE (exactly one cycle):
  - rx_ready=0, mem_we=1, mem_addr=ptr, mem_wdata=latched byte.
  - sum += byte (mod 256); ptr += 1 (wraps 255->0); count -= 1.
  - If the decremented count is 0: go to CHECK if LOADER_CSUM_EN is defined, otherwise RUN. Else go to LOAD.
  - Throughput: at most one byte per 2 cycles.
- CHECK: see Optional Feature.
- RUN:
  - cpu_run=1 (asserted the first cycle after the final WRITE), rx_ready=0.
  - mem_addr=cpu_addr, mem_wdata=cpu_data_out, mem_we=cpu_we, cpu_data_in=mem_rdata; all combinational, zero added latency.
  - rx bytes are ignored.
- Outside RUN:
  - cpu_data_in=0; the CPU bus is ignored entirely (cpu_we never reaches RAM).
  - mem_addr/mem_wdata are undriven-by-CPU, i.e. they reflect the loader.
- reload:
  - In RUN: next state=WAIT_LEN; cpu_run drops the next cycle; ptr=0, count=0, sum=0.
  - Ignored in all other states.
- Simultaneous events:
  - rst beats reload.
  - rst beats any accept: a byte presented in the reset cycle is discarded.
- ERROR:
  - cpu_run=0, rx_ready=0, load_err=1.
  - Left only by rst.

Optional Feature:
- Macro: LOADER_CSUM_EN.
- Defined:
  - After the N data bytes, CHECK has rx_ready=1 and accepts one checksum byte C.
  - If C == sum (8-bit two's-complement sum of the N data bytes) -> RUN.
  - Otherwise -> ERROR with load_err=1.
  - C is never written to RAM.
- Not defined:
  - No CHECK state; the final WRITE goes directly to RUN.
  - load_err is tied to 0; the sum register may be omitted.

Test Plan:
1. Reset, stream 03,40,41,C5 with rx_valid continuous -> writes 40@00, 41@01, C5@02 on three single-cycle mem_we pulses. rx_ready toggles 1,0 per byte. cpu_run=1 the cycle after the third write; without CSUM, no further byte is consumed.
2. Length 00 followed by 256 bytes (values 00..FF) -> 256 writes at addresses 00..FF, ptr wraps to 00, then RUN. Insert random rx_valid gaps -> identical RAM contents.
3. Assert rst after the 2nd data byte of a 5-byte load -> mem_we=0 and cpu_run=0 the next cycle, state WAIT_LEN. A fresh 02,AA,BB load writes AA@00, BB@01.
4. In RUN, drive cpu_addr=12, cpu_we=1, cpu_data_out=7E -> same-cycle mem_we=1, mem_addr=12, mem_wdata=7E. Then cpu_we=0 with mem_rdata=33 -> cpu_data_in=33 combinationally. Outside RUN, cpu_we=1 -> mem_we=0.
5. In RUN, pulse reload -> cpu_run=0 the next cycle, rx_ready=1. Load 01,99 -> 99@00, back to RUN. reload and rst in the same cycle -> reset state.
6. LOADER_CSUM_EN: 02,10,20,30 -> RUN, load_err=0. 02,10,20,31 -> ERROR, load_err=1, cpu_run=0, rx_ready=0 until rst.

Source files
------------

// File: rtl/prog_loader.sv
// Boot loader between the 8-bit CPU and the shared program/data RAM.
// Fills RAM from a length-prefixed byte stream, then releases the CPU.
// Ports: clk/rst (sync, active-high); rx_data/rx_valid/rx_ready stream;
//   reload pulse; cpu_addr/cpu_data_out/cpu_we/cpu_data_in CPU bus;
//   mem_addr/mem_wdata/mem_we/mem_rdata RAM bus; cpu_run; load_err.
// Build option: define LOADER_CSUM_EN to require a trailing checksum byte.
module prog_loader #(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [DATA_W-1:0] rx_data,
  input  logic              rx_valid,
  output logic              rx_ready,
  input  logic              reload,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_data_out,
  input  logic              cpu_we,
  output logic [DATA_W-1:0] cpu_data_in,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic              mem_we,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              cpu_run,
  output logic              load_err
);

  typedef enum logic [2:0] {
    WAIT_LEN,
    LOAD,
    WRITE,
    CHECK,
    RUN,
    ERROR
  } state_t;

  state_t            state;
  logic [ADDR_W-1:0] ptr;
  logic [ADDR_W:0]   count;
  logic [DATA_W-1:0] byte_q;
  logic              rdy_q;
  logic              we_q;
  logic              run_q;
  logic              err_q;

  logic [ADDR_W:0]   len;
  logic [ADDR_W:0]   count_dec;
  logic              acc;

`ifdef LOADER_CSUM_EN
  logic [DATA_W-1:0] sum;
  localparam state_t LAST_ST = CHECK;
`else
  localparam state_t LAST_ST = RUN;
`endif

  assign acc       = rx_valid && rdy_q;
  assign count_dec = count - 1'b1;

  // A length byte of zero stands for a full 2**ADDR_W image.
  always_comb begin
    len = (ADDR_W+1)'(rx_data);
    if (rx_data == '0) begin
      len = {1'b1, {ADDR_W{1'b0}}};
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= WAIT_LEN;
      ptr    <= '0;
      count  <= '0;
      byte_q <= '0;
      rdy_q  <= 1'b1;
      we_q   <= 1'b0;
      run_q  <= 1'b0;
      err_q  <= 1'b0;
`ifdef LOADER_CSUM_EN
      sum    <= '0;
`endif
    end else begin
      unique case (state)
        WAIT_LEN: begin
          if (acc) begin
            count <= len;
            ptr   <= '0;
`ifdef LOADER_CSUM_EN
            sum   <= '0;
`endif
            state <= LOAD;
          end
        end
        LOAD: begin
          if (acc) begin
            byte_q <= rx_data;
            rdy_q  <= 1'b0;
            we_q   <= 1'b1;
            state  <= WRITE;
          end
        end
        WRITE: begin
          we_q  <= 1'b0;
          ptr   <= ptr + 1'b1;
          count <= count_dec;
`ifdef LOADER_CSUM_EN
          sum   <= sum + byte_q;
`endif
          if (count_dec == '0) begin
            state <= LAST_ST;
            rdy_q <= (LAST_ST == CHECK);
            run_q <= (LAST_ST == RUN);
          end else begin
            state <= LOAD;
            rdy_q <= 1'b1;
          end
        end
`ifdef LOADER_CSUM_EN
        CHECK: begin
          if (acc) begin
            rdy_q <= 1'b0;
            if (rx_data == sum) begin
              state <= RUN;
              run_q <= 1'b1;
            end else begin
              state <= ERROR;
              err_q <= 1'b1;
            end
          end
        end
`endif
        RUN: begin
          if (reload) begin
            state <= WAIT_LEN;
            ptr   <= '0;
            count <= '0;
`ifdef LOADER_CSUM_EN
            sum   <= '0;
`endif
            run_q <= 1'b0;
            rdy_q <= 1'b1;
          end
        end
        default: begin
          state <= state;
        end
      endcase
    end
  end

  // CPU bus reaches RAM only while released; otherwise the loader owns it.
  assign rx_ready    = rdy_q;
  assign cpu_run     = run_q;
  assign mem_addr    = run_q ? cpu_addr : ptr;
  assign mem_wdata   = run_q ? cpu_data_out : byte_q;
  assign mem_we      = run_q ? cpu_we : we_q;
  assign cpu_data_in = run_q ? mem_rdata : '0;

`ifdef LOADER_CSUM_EN
  assign load_err = err_q;
`else
  assign load_err = 1'b0;
`endif

endmodule
